regbank_read_arbiter: RTL and testbench

- Clocked arbiter sharing the single regbank read port (toggle trigger / ready / data) among NREQ requesters.
- Requesters: decode operand fetch slots, debug, and similar.
- Each requester raises a level request with a register address. The arbiter picks one by round-robin, issues one regbank read by toggling triggerOutRB, waits for readyInRB, then returns the data with a one-cycle readyOut pulse to the winner.
- Sits between decode (and other readers) and regbank.

---
 rtl/regbank_read_arbiter_pkg.sv | 20 ++
 rtl/regbank_read_arbiter_rr_pick.sv | 34 +++
 rtl/regbank_read_arbiter.sv | 168 ++++++++++++++++
 tb/tb_regbank_read_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_read_arbiter_pkg.sv
// Shared types and constants for the regbank read-port arbiter and its round-robin picker.
// The optional WAIT timeout is enabled by defining RB_ARB_TIMEOUT_EN.
package regbank_read_arbiter_pkg;

   localparam int unsigned RB_ARB_ADDR_W   = 4;
   localparam int unsigned RB_ARB_DATA_W   = 32;
   localparam logic [31:0] RB_ARB_ERR_DATA = 32'hDEADBEEF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } rb_arb_state_e;

   // Index width for a requester count; never below one bit.
   function automatic int unsigned rb_arb_idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/regbank_read_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping to 0.
module regbank_read_arbiter_rr_pick
   import regbank_read_arbiter_pkg::*;
#(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned IDX_W = rb_arb_idx_w(NREQ)
) (
   input  logic [NREQ-1:0]  req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [NREQ-1:0]  grant_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] p, input int unsigned off);
      return IDX_W'((32'(p) + off) % NREQ);
   endfunction

   // Scan from the farthest offset down so the nearest request is written last and wins.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      for (int i = int'(NREQ) - 1; i >= 0; i--) begin
         if (req_i[wrap_idx(ptr_i, 32'(i))]) begin
            grant_o                           = '0;
            grant_o[wrap_idx(ptr_i, 32'(i))]  = 1'b1;
            idx_o                             = wrap_idx(ptr_i, 32'(i));
            any_o                             = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regbank_read_arbiter.sv
// Round-robin arbiter sharing the regbank toggle-trigger read port among NREQ requesters.
// Define RB_ARB_TIMEOUT_EN to add a WAIT-state timeout returning RB_ARB_ERR_DATA with errOut.
module regbank_read_arbiter
   import regbank_read_arbiter_pkg::*;
#(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned ADDR_W  = RB_ARB_ADDR_W,
   parameter int unsigned DATA_W  = RB_ARB_DATA_W
`ifdef RB_ARB_TIMEOUT_EN
   ,parameter int unsigned TIMEOUT = 16
`endif
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREQ-1:0]        reqIn,
   input  logic [NREQ*ADDR_W-1:0] addrIn,
   output logic [NREQ-1:0]        grantOut,
   output logic [NREQ-1:0]        readyOut,
   output logic [DATA_W-1:0]      dataOut,
   output logic                   busyOut,
   output logic                   errOut,
   output logic                   triggerOutRB,
   output logic [31:0]            addrRB,
   input  logic                   readyInRB,
   input  logic [DATA_W-1:0]      dataInRB
);

   localparam int unsigned IDX_W = rb_arb_idx_w(NREQ);

   rb_arb_state_e     state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [31:0]       addr_q, addr_d;
   logic              trig_q, trig_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic [NREQ-1:0]   ready_q, ready_d;
   logic              busy_q;

   logic [NREQ-1:0]   pick_grant;
   logic [IDX_W-1:0]  pick_idx;
   logic              pick_any;
   logic [ADDR_W-1:0] pick_addr;

`ifdef RB_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;
`endif

   regbank_read_arbiter_rr_pick #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req_i   (reqIn),
      .ptr_i   (ptr_q),
      .grant_o (pick_grant),
      .idx_o   (pick_idx),
      .any_o   (pick_any)
   );

   assign pick_addr = addrIn[32'(pick_idx)*ADDR_W +: ADDR_W];

   // Next-state and registered-output values; reqIn is only looked at in IDLE.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      trig_d  = trig_q;
      data_d  = data_q;
      grant_d = grant_q;
      ready_d = '0;
`ifdef RB_ARB_TIMEOUT_EN
      err_d   = 1'b0;
      cnt_d   = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               idx_d   = pick_idx;
               addr_d  = 32'(pick_addr);
               trig_d  = ~trig_q;
               grant_d = pick_grant;
               state_d = WAIT;
`ifdef RB_ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         WAIT: begin
            // A completion arriving on the limit cycle still delivers real data.
            if (readyInRB) begin
               data_d  = dataInRB;
               ready_d = grant_q;
               state_d = RESP;
            end
`ifdef RB_ARB_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               data_d  = DATA_W'(RB_ARB_ERR_DATA);
               ready_d = grant_q;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
`endif
         end
         RESP: begin
            ptr_d   = IDX_W'((32'(idx_q) + 32'd1) % NREQ);
            grant_d = '0;
            state_d = IDLE;
         end
         default: begin
            grant_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
         trig_q  <= 1'b0;
         data_q  <= '0;
         grant_q <= '0;
         ready_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         trig_q  <= trig_d;
         data_q  <= data_d;
         grant_q <= grant_d;
         ready_q <= ready_d;
         busy_q  <= (state_d != IDLE);
      end
   end

`ifdef RB_ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign errOut = err_q;
`else
   assign errOut = 1'b0;
`endif

   assign grantOut     = grant_q;
   assign readyOut     = ready_q;
   assign dataOut      = data_q;
   assign busyOut      = busy_q;
   assign triggerOutRB = trig_q;
   assign addrRB       = addr_q;

endmodule

// File: tb/tb_regbank_read_arbiter.sv
// Scoreboard bench for regbank_read_arbiter: stimulus queues expected responses, a monitor checks readyOut pulses.
module tb_regbank_read_arbiter;

   typedef struct {
      logic [3:0]  rdy;
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [3:0]  reqIn;
   logic [15:0] addrIn;
   logic [3:0]  grantOut;
   logic [3:0]  readyOut;
   logic [31:0] dataOut;
   logic        busyOut;
   logic        errOut;
   logic        triggerOutRB;
   logic [31:0] addrRB;
   logic        readyInRB;
   logic [31:0] dataInRB;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   toggles = 0;
   logic trig_seen;

   regbank_read_arbiter dut (
      .clk          (clk),
      .reset        (reset),
      .reqIn        (reqIn),
      .addrIn       (addrIn),
      .grantOut     (grantOut),
      .readyOut     (readyOut),
      .dataOut      (dataOut),
      .busyOut      (busyOut),
      .errOut       (errOut),
      .triggerOutRB (triggerOutRB),
      .addrRB       (addrRB),
      .readyInRB    (readyInRB),
      .dataInRB     (dataInRB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Regbank contents for the addresses the stimulus uses.
   function automatic logic [31:0] rb_val(input logic [3:0] a);
      case (a)
         4'd3:    return 32'h0000_00CC;
         4'd5:    return 32'h5555_0005;
         4'd7:    return 32'h7777_0007;
         4'd9:    return 32'h9999_0009;
         4'd12:   return 32'hC0C0_000C;
         default: return 32'hBAD0_0000;
      endcase
   endfunction

   task automatic expect_rsp(input logic [3:0] rdy, input logic [31:0] data, input logic err);
      exp_t e;
      e.rdy  = rdy;
      e.data = data;
      e.err  = err;
      exp_q.push_back(e);
   endtask

   // Monitor: every readyOut pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (!reset) begin
         if (readyOut != 4'b0000) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_readyOut", 32'(readyOut), 32'h0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("readyOut", 32'(readyOut), 32'(e.rdy));
               chk("dataOut", dataOut, e.data);
               chk("errOut", 32'(errOut), 32'(e.err));
               chk("grant_with_ready", 32'(grantOut), 32'(e.rdy));
            end
         end else if (errOut) begin
            chk("errOut_without_ready", 32'(errOut), 32'h0);
         end
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_grantOut"}, 32'(grantOut), 32'h0);
      chk({tag, "_readyOut"}, 32'(readyOut), 32'h0);
      chk({tag, "_dataOut"}, dataOut, 32'h0);
      chk({tag, "_busyOut"}, 32'(busyOut), 32'h0);
      chk({tag, "_errOut"}, 32'(errOut), 32'h0);
      chk({tag, "_trigger"}, 32'(triggerOutRB), 32'h0);
      chk({tag, "_addrRB"}, addrRB, 32'h0);
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      reset     = 1'b1;
      reqIn     = '0;
      readyInRB = 1'b0;
      repeat (cycles) @(negedge clk);
      reset     = 1'b0;
      trig_seen = 1'b0;
   endtask

   // Wait for an issue (trigger toggle) and check what was issued.
   task automatic wait_trig(input logic [31:0] exp_addr, input logic [3:0] exp_grant);
      int n;
      n = 0;
      while (triggerOutRB == trig_seen && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("trigger_toggle", 32'(triggerOutRB != trig_seen), 32'h1);
      trig_seen = triggerOutRB;
      toggles++;
      chk("addrRB", addrRB, exp_addr);
      chk("grantOut", 32'(grantOut), 32'(exp_grant));
      chk("busyOut_wait", 32'(busyOut), 32'h1);
   endtask

   // Regbank side: hold off for delay cycles, then a one-cycle completion.
   task automatic respond(input int delay);
      logic [31:0] a;
      logic [3:0]  g;
      a = addrRB;
      g = grantOut;
      repeat (delay) begin
         @(negedge clk);
         chk("hold_addrRB", addrRB, a);
         chk("hold_grant", 32'(grantOut), 32'(g));
         chk("hold_trigger", 32'(triggerOutRB), 32'(trig_seen));
      end
      readyInRB = 1'b1;
      dataInRB  = rb_val(addrRB[3:0]);
      @(negedge clk);
      readyInRB = 1'b0;
      dataInRB  = '0;
   endtask

   // Requester side: wait for its readyOut within budget, then drop the request.
   task automatic wait_ready(input logic [3:0] mask, input int budget);
      int n;
      n = 0;
      while (readyOut != mask && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("readyOut_arrival", 32'(readyOut), 32'(mask));
      reqIn = reqIn & ~mask;
   endtask

   logic [31:0] cont_addr [5] = '{32'd5, 32'd9, 32'd12, 32'd7, 32'd5};
   logic [3:0]  cont_gnt  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [31:0] cont_data [5] = '{32'h5555_0005, 32'h9999_0009, 32'hC0C0_000C, 32'h7777_0007, 32'h5555_0005};

   initial begin
      reset     = 1'b1;
      reqIn     = '0;
      addrIn    = '0;
      readyInRB = 1'b0;
      dataInRB  = '0;
      trig_seen = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk_all_zero("reset");

      // Single request from requester 0 for r3.
      addrIn = {4'd7, 4'd12, 4'd9, 4'd3};
      expect_rsp(4'b0001, 32'h0000_00CC, 1'b0);
      reqIn = 4'b0001;
      wait_trig(32'd3, 4'b0001);
      chk("trigger_rise", 32'(triggerOutRB), 32'h1);
      respond(0);
      wait_ready(4'b0001, 0);
      repeat (3) @(negedge clk);
      chk("dataOut_hold", dataOut, 32'h0000_00CC);
      chk("busy_idle", 32'(busyOut), 32'h0);

      // Contention from pointer 0: order 0,1,2,3,0.
      do_reset(2);
      chk_all_zero("reset2");
      addrIn  = {4'd7, 4'd12, 4'd9, 4'd5};
      toggles = 0;
      for (int i = 0; i < 5; i++) expect_rsp(cont_gnt[i], cont_data[i], 1'b0);
      reqIn = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         wait_trig(cont_addr[i], cont_gnt[i]);
         respond(0);
      end
      wait_ready(4'b0001, 0);
      reqIn = '0;
      chk("toggle_count", 32'(toggles), 32'd5);

      // Pointer wrap: serve 3, then 1001 -> 0 first, then 3.
      expect_rsp(4'b1000, 32'h7777_0007, 1'b0);
      reqIn = 4'b1000;
      wait_trig(32'd7, 4'b1000);
      respond(0);
      wait_ready(4'b1000, 0);
      expect_rsp(4'b0001, 32'h5555_0005, 1'b0);
      expect_rsp(4'b1000, 32'h7777_0007, 1'b0);
      reqIn = 4'b1001;
      wait_trig(32'd5, 4'b0001);
      respond(0);
      wait_ready(4'b0001, 0);
      wait_trig(32'd7, 4'b1000);
      respond(0);
      wait_ready(4'b1000, 0);

      // Slow regbank plus addrIn change while granted, then stray completions.
      expect_rsp(4'b0010, 32'h9999_0009, 1'b0);
      reqIn = 4'b0010;
      wait_trig(32'd9, 4'b0010);
      addrIn = 16'hFFFF;
      respond(5);
      wait_ready(4'b0010, 0);
      addrIn    = {4'd7, 4'd12, 4'd9, 4'd5};
      readyInRB = 1'b1;
      dataInRB  = 32'h1234_5678;
      repeat (3) @(negedge clk);
      readyInRB = 1'b0;
      dataInRB  = '0;
      @(negedge clk);
      chk("stray_readyOut", 32'(readyOut), 32'h0);
      chk("stray_busy", 32'(busyOut), 32'h0);
      chk("stray_dataOut", dataOut, 32'h9999_0009);

      // Reset while in WAIT, late completion, then pointer back at 0.
      reqIn = 4'b0100;
      wait_trig(32'd12, 4'b0100);
      @(negedge clk);
      do_reset(1);
      chk_all_zero("midwait");
      readyInRB = 1'b1;
      dataInRB  = 32'h5A5A_5A5A;
      @(negedge clk);
      readyInRB = 1'b0;
      dataInRB  = '0;
      @(negedge clk);
      chk("late_readyOut", 32'(readyOut), 32'h0);
      chk("late_busy", 32'(busyOut), 32'h0);
      expect_rsp(4'b0010, 32'h9999_0009, 1'b0);
      expect_rsp(4'b1000, 32'h7777_0007, 1'b0);
      reqIn = 4'b1010;
      wait_trig(32'd9, 4'b0010);
      respond(0);
      wait_ready(4'b0010, 0);
      wait_trig(32'd7, 4'b1000);
      respond(0);
      wait_ready(4'b1000, 0);

      // Regbank never answers.
`ifdef RB_ARB_TIMEOUT_EN
      begin
         int n;
         expect_rsp(4'b0001, 32'hDEAD_BEEF, 1'b1);
         reqIn = 4'b0001;
         wait_trig(32'd5, 4'b0001);
         n = 0;
         while (readyOut == 4'b0000 && n < 40) begin
            @(negedge clk);
            n++;
         end
         chk("timeout_latency", 32'(n), 32'd16);
         wait_ready(4'b0001, 0);
      end
`else
      reqIn = 4'b0001;
      wait_trig(32'd5, 4'b0001);
      repeat (40) @(negedge clk);
      chk("noresp_busy", 32'(busyOut), 32'h1);
      chk("noresp_readyOut", 32'(readyOut), 32'h0);
      do_reset(1);
`endif

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
